// File: rtl/xor_pipe_if.sv
// rtl/xor_pipe_if.sv - operand/result handshake bundle for xor_pipe
//
// Groups the input transaction (in_valid/in_ready, a, b, mode) and the
// output result (out_valid/out_ready, y, parity, zero) of xor_pipe.
//   master : the side that issues operands and consumes results
//   slave  : the xor_pipe unit itself
interface xor_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             parity;
  logic             zero;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, y, parity, zero
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, y, parity, zero
  );
endinterface

// File: rtl/xor_pipe.sv
// rtl/xor_pipe.sv - pipelined XOR/XNOR unit with parity and zero flags
//
// Computes y = a^b (mode=0) or ~(a^b) (mode=1), with parity = ^y and
// zero = (y == 0), through STAGES elastic register stages.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : xor_pipe_if slave port
//           in_valid/in_ready/a/b/mode    operand transaction
//           out_valid/out_ready/y/parity/zero  result
module xor_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input logic       clk,
  input logic       rst_n,
  xor_pipe_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 128) begin : g_bad_width
    $error("xor_pipe: WIDTH must be in 1..128");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("xor_pipe: STAGES must be in 1..4");
  end

  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  y_q [STAGES];
  logic [STAGES-1:0] par_q;
  logic [STAGES-1:0] zero_q;

  logic [STAGES-1:0] load;
  logic              full_tail;
  logic [WIDTH-1:0]  op_y;

  assign op_y = bus.mode ? ~(bus.a ^ bus.b) : (bus.a ^ bus.b);

  // Ready chain, walked from the output back to the input. A stage loads
  // when it is empty or when it can pass its entry on; that is only
  // impossible when it and every stage after it are full and the consumer
  // is stalling. Empty stages ahead of a stall therefore still load, which
  // collapses bubbles.
  always_comb begin
    full_tail = 1'b1;
    load      = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full_tail = full_tail & v_q[k];
      load[k]   = bus.out_ready | ~full_tail;
    end
  end

  // The flags are derived at entry so y, parity and zero of one transaction
  // always travel down the pipe as a single entry. Data registers only
  // capture when a valid entry arrives, so idle operand changes are ignored
  // and a stalled output stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      par_q  <= '0;
      zero_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        y_q[k] <= '0;
      end
    end else begin
      if (load[0]) begin
        v_q[0] <= bus.in_valid;
        if (bus.in_valid) begin
          y_q[0]    <= op_y;
          par_q[0]  <= ^op_y;
          zero_q[0] <= ~|op_y;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            y_q[k]    <= y_q[k-1];
            par_q[k]  <= par_q[k-1];
            zero_q[k] <= zero_q[k-1];
          end
        end
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.y         = y_q[STAGES-1];
  assign bus.parity    = par_q[STAGES-1];
  assign bus.zero      = zero_q[STAGES-1];

endmodule

// File: tb/tb_xor_pipe.sv
// tb/tb_xor_pipe.sv - self-checking bench for xor_pipe
module tb_xor_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit sweep_go = 1'b0;

  task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {zero, parity, y} straight from the operation definition.
  function automatic logic [65:0] model64(input logic [63:0] ta, input logic [63:0] tbv, input bit tm);
    logic [63:0] r;
    int ones;
    r = ta ^ tbv;
    if (tm) r = ~r;
    ones = 0;
    for (int i = 0; i < 64; i++) ones += int'(r[i]);
    return {r == 64'd0, ones % 2 == 1, r};
  endfunction

  // ---------------- main instance, WIDTH=64, STAGES=2 ----------------
  xor_pipe_if #(.WIDTH(64)) bus ();
  xor_pipe #(.WIDTH(64), .STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  logic [65:0] q[$];
  bit          hold;
  logic [66:0] held;
  bit          del_seen, last_acc, last_ov;
  logic [65:0] del_val;

  task automatic step_op(input bit iv, input bit ordy, input logic [63:0] ta,
                         input logic [63:0] tbv, input bit tm);
    logic [66:0] obs;
    bus.in_valid  = iv;
    bus.a         = ta;
    bus.b         = tbv;
    bus.mode      = tm;
    bus.out_ready = ordy;
    @(negedge clk);
    obs = {bus.out_valid, bus.zero, bus.parity, bus.y};
    check("in_ready", 132'(bus.in_ready), 132'((q.size() < 2) || ordy));
    if (hold) check("hold_stable", 132'(obs), 132'(held));
    if (q.size() == 0) check("no_stale_valid", 132'(bus.out_valid), 132'(0));
    del_seen = bus.out_valid && ordy && (q.size() > 0);
    del_val  = obs[65:0];
    if (del_seen) check("result", 132'(obs[65:0]), 132'(q.pop_front()));
    last_acc = iv && bus.in_ready;
    last_ov  = bus.out_valid;
    if (last_acc) q.push_back(model64(ta, tbv, tm));
    hold = bus.out_valid && !ordy;
    held = obs;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit iv, input bit ordy);
    step_op(iv, ordy, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
  endtask

  task automatic directed(input string tag, input logic [63:0] ta, input logic [63:0] tbv,
                          input bit tm, input logic [63:0] ey, input bit ep, input bit ez);
    int lat;
    lat = 0;
    step_op(1'b1, 1'b1, ta, tbv, tm);
    check({tag, "_accept"}, 132'(last_acc), 132'(1));
    while (!del_seen && lat < 8) begin
      step(1'b0, 1'b1);
      lat++;
    end
    check({tag, "_latency"}, 132'(lat), 132'(2));
    check({tag, "_value"}, 132'(del_val), 132'({ez, ep, ey}));
  endtask

  // ---------------- parameter sweep instances ----------------
  for (genvar g = 0; g < 6; g++) begin : g_sw
    localparam int W = (g < 2) ? 1 : (g < 4) ? 53 : 128;
    localparam int S = (g % 2 == 0) ? 1 : 4;
    localparam int N = 1000;
    bit done = 1'b0;

    xor_pipe_if #(.WIDTH(W)) sb ();
    xor_pipe #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(sb.slave));

    initial begin : drv
      string        pfx;
      logic [127:0] r;
      logic [W-1:0] ta, tbv, ty;
      bit           tm, iv, ordy, shold, got;
      logic [W+1:0] sq[$];
      logic [W+2:0] sheld, obs;
      int           sent, cyc, lat, ones;

      pfx = $sformatf("W%0dS%0d", W, S);
      sb.in_valid = 1'b0; sb.a = '0; sb.b = '0; sb.mode = 1'b0; sb.out_ready = 1'b1;
      wait (sweep_go);
      @(posedge clk);
      #1;

      // unstalled latency of one transaction into an empty pipe
      r = {$urandom, $urandom, $urandom, $urandom};
      ta = r[W-1:0]; tbv = r[127:128-W]; tm = 1'b0;
      sb.a = ta; sb.b = tbv; sb.mode = tm; sb.in_valid = 1'b1;
      @(negedge clk);
      check({pfx, "_lat_accept"}, 132'(sb.in_ready), 132'(1));
      @(posedge clk);
      #1;
      sb.in_valid = 1'b0;
      lat = 0; got = 1'b0;
      while (!got && lat < 10) begin
        @(negedge clk);
        lat++;
        if (sb.out_valid) begin
          got = 1'b1;
          check({pfx, "_lat_value"}, 132'(sb.y), 132'(ta ^ tbv));
        end
        @(posedge clk);
        #1;
      end
      check({pfx, "_latency"}, 132'(lat), 132'(S));

      // random traffic with random valid/ready
      sent = 0; cyc = 0; shold = 1'b0;
      while ((sent < N || sq.size() > 0) && cyc < 20000) begin
        r = {$urandom, $urandom, $urandom, $urandom};
        ta = r[W-1:0];
        r = {$urandom, $urandom, $urandom, $urandom};
        tbv = r[W-1:0];
        tm = 1'($urandom_range(0, 1));
        iv = (sent < N) && ($urandom_range(0, 9) < 7);
        ordy = ($urandom_range(0, 9) < 7);
        sb.a = ta; sb.b = tbv; sb.mode = tm; sb.in_valid = iv; sb.out_ready = ordy;
        @(negedge clk);
        obs = {sb.out_valid, sb.zero, sb.parity, sb.y};
        check({pfx, "_in_ready"}, 132'(sb.in_ready), 132'((sq.size() < S) || ordy));
        if (shold) check({pfx, "_hold"}, 132'(obs), 132'(sheld));
        if (sq.size() == 0) check({pfx, "_no_stale"}, 132'(sb.out_valid), 132'(0));
        if (sb.out_valid && ordy && sq.size() > 0) begin
          check({pfx, "_result"}, 132'(obs[W+1:0]), 132'(sq.pop_front()));
          check({pfx, "_parity_vs_y"}, 132'(sb.parity), 132'(^sb.y));
        end
        if (iv && sb.in_ready) begin
          ty = tm ? ~(ta ^ tbv) : (ta ^ tbv);
          ones = 0;
          for (int i = 0; i < W; i++) ones += int'(ty[i]);
          sq.push_back({ty == '0, ones % 2 == 1, ty});
          sent++;
        end
        shold = sb.out_valid && !ordy;
        sheld = obs;
        @(posedge clk);
        #1;
        cyc++;
      end
      check({pfx, "_all_sent"}, 132'(sent), 132'(N));
      check({pfx, "_drained"}, 132'(sq.size()), 132'(0));
      sb.in_valid = 1'b0;
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int  acc_stall, sent;
    bit  fell, iv, ordy, all_done;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.mode = 1'b0; bus.out_ready = 1'b1;
    hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 132'(bus.out_valid), 132'(0));
    check("rst_y", 132'(bus.y), 132'(0));
    check("rst_parity", 132'(bus.parity), 132'(0));
    check("rst_zero", 132'(bus.zero), 132'(0));
    check("rst_in_ready", 132'(bus.in_ready), 132'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", 132'(bus.in_ready), 132'(1));
    @(posedge clk);
    #1;

    // basic XOR, XNOR, zero and parity flags
    directed("basic_xor", 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 1'b0,
             64'hF0F00F0FF0F00F0F, 1'b0, 1'b0);
    directed("equal_xor", 64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 1'b0,
             64'h0, 1'b0, 1'b1);
    directed("equal_xnor", 64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 1'b1,
             64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
    directed("odd_parity", 64'h1, 64'h0, 1'b0, 64'h1, 1'b1, 1'b0);

    // backpressure: out_ready low for cycles 3..8, pipe empty when it starts
    acc_stall = 0; fell = 1'b0; sent = 0;
    for (int c = 0; c < 40 && (sent < 10 || q.size() > 0); c++) begin
      iv = (sent < 10) && (c == 0 || c >= 3);
      ordy = !(c >= 3 && c <= 8);
      step(iv, ordy);
      if (!ordy && !fell) begin
        if (!bus.in_ready && !last_acc && iv) fell = 1'b1;
        else if (last_acc) acc_stall++;
      end
      if (last_acc) sent++;
    end
    check("bp_stalled_accepts", 132'(acc_stall), 132'(2));
    check("bp_in_ready_fell", 132'(fell), 132'(1));
    check("bp_sent", 132'(sent), 132'(10));
    check("bp_drained", 132'(q.size()), 132'(0));

    // full pipe, simultaneous accept and deliver every cycle
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 1'b1);
      check("fr_accept", 132'(last_acc), 132'(1));
      check("fr_deliver", 132'(del_seen), 132'(1));
      check("fr_occupancy", 132'(q.size()), 132'(2));
    end
    repeat (4) step(1'b0, 1'b1);
    check("fr_drained", 132'(q.size()), 132'(0));

    // reset with two results in flight
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("mid_rst_pre_valid", 132'(bus.out_valid), 132'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 132'(bus.out_valid), 132'(0));
    check("mid_rst_y", 132'(bus.y), 132'(0));
    check("mid_rst_in_ready", 132'(bus.in_ready), 132'(1));
    bus.in_valid = 1'b0;
    q.delete();
    hold = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b1);
      check("mid_rst_quiet", 132'(last_ov), 132'(0));
    end

    // parameter sweep runs concurrently on its own instances
    sweep_go = 1'b1;
    all_done = 1'b0;
    for (int c = 0; c < 40000 && !all_done; c++) begin
      @(posedge clk);
      all_done = g_sw[0].done && g_sw[1].done && g_sw[2].done &&
                 g_sw[3].done && g_sw[4].done && g_sw[5].done;
    end
    check("sweep_finished", 132'(all_done), 132'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
